// File: rtl/inst_buffer.sv
// Dual-slot instruction buffer between fetch and decode.
// Slot [1] is always the older instruction on both sides.
module inst_buffer #(
    parameter  int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       in_valid,
    input  logic [1:0][31:0] in_pc,
    input  logic [1:0][31:0] in_instr,
    input  logic [1:0]       in_is_br,
    output logic             in_ready,
    input  logic             flush,
    input  logic             stall,
    output logic [1:0]       out_valid,
    output logic [1:0][31:0] out_pc,
    output logic [1:0][31:0] out_instr,
    output logic [1:0]       out_is_br,
    output logic [PTR_W:0]   count
);

    logic [31:0]      pc_mem_q    [DEPTH];
    logic [31:0]      instr_mem_q [DEPTH];
    logic             br_mem_q    [DEPTH];

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [PTR_W-1:0] head_nxt, tail_nxt;
    logic [PTR_W:0]   count_q, count_d;

    logic             enq, deq;
    logic [1:0]       nenq, ndeq;
    logic             a_br, b_br;

    logic [31:0]      wr0_pc, wr0_instr;
    logic             wr0_br;

    assign head_nxt = head_q + PTR_W'(1);
    assign tail_nxt = tail_q + PTR_W'(1);

    assign a_br = br_mem_q[head_q];
    assign b_br = br_mem_q[head_nxt];

    assign in_ready = (count_q <= (PTR_W+1)'(DEPTH - 2));
    assign count    = count_q;

    assign enq = in_ready & ~flush & ~reset;
    assign deq = ~stall & ~flush & ~reset;

    // A branch at the head is only released together with its delay slot.
    always_comb begin
        out_valid = 2'b00;
        if (count_q == '0) begin
            out_valid = 2'b00;
        end else if (a_br) begin
            out_valid = (count_q >= (PTR_W+1)'(2)) ? 2'b11 : 2'b00;
        end else if (count_q == (PTR_W+1)'(1)) begin
            out_valid = 2'b10;
        end else if (b_br) begin
            out_valid = 2'b10;
        end else begin
            out_valid = 2'b11;
        end
    end

    always_comb begin
        out_pc[1]    = pc_mem_q[head_q];
        out_pc[0]    = pc_mem_q[head_nxt];
        out_instr[1] = instr_mem_q[head_q];
        out_instr[0] = instr_mem_q[head_nxt];
        out_is_br[1] = br_mem_q[head_q];
        out_is_br[0] = br_mem_q[head_nxt];
    end

    always_comb begin
        nenq = 2'd0;
        ndeq = 2'd0;
        if (enq) begin
            nenq = {1'b0, in_valid[1]} + {1'b0, in_valid[0]};
        end
        if (deq) begin
            ndeq = {1'b0, out_valid[1]} + {1'b0, out_valid[0]};
        end
    end

    always_comb begin
        head_d  = head_q + PTR_W'(ndeq);
        tail_d  = tail_q + PTR_W'(nenq);
        count_d = count_q + (PTR_W+1)'(nenq) - (PTR_W+1)'(ndeq);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // A lone slot-0 enqueue lands at tail just like a lone slot 1.
    always_comb begin
        wr0_pc    = in_valid[1] ? in_pc[1]    : in_pc[0];
        wr0_instr = in_valid[1] ? in_instr[1] : in_instr[0];
        wr0_br    = in_valid[1] ? in_is_br[1] : in_is_br[0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq && (in_valid != 2'b00)) begin
            pc_mem_q[tail_q]    <= wr0_pc;
            instr_mem_q[tail_q] <= wr0_instr;
            br_mem_q[tail_q]    <= wr0_br;
        end
        if (enq && (in_valid == 2'b11)) begin
            pc_mem_q[tail_nxt]    <= in_pc[0];
            instr_mem_q[tail_nxt] <= in_instr[0];
            br_mem_q[tail_nxt]    <= in_is_br[0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (count_q <= (PTR_W+1)'(DEPTH));
            assert ((PTR_W+1)'(ndeq) <= count_q);
        end
    end

endmodule

// File: tb/tb_inst_buffer.sv
// Scoreboard-driven bench for the dual-slot instruction buffer.
module tb_inst_buffer;

    localparam int DEPTH = 16;
    localparam int PTR_W = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       in_valid;
    logic [1:0][31:0] in_pc;
    logic [1:0][31:0] in_instr;
    logic [1:0]       in_is_br;
    logic             in_ready;
    logic             flush;
    logic             stall;
    logic [1:0]       out_valid;
    logic [1:0][31:0] out_pc;
    logic [1:0][31:0] out_instr;
    logic [1:0]       out_is_br;
    logic [PTR_W:0]   count;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        br;
    } ent_t;

    ent_t sb[$];
    int   checks = 0;
    int   passes = 0;
    int   deq_total = 0;

    inst_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
        .in_is_br(in_is_br), .in_ready(in_ready),
        .flush(flush), .stall(stall),
        .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
        .out_is_br(out_is_br), .count(count)
    );

    always #5 clk = ~clk;

    // Mid-cycle monitor: retire presented slots, then record accepted ones.
    always @(negedge clk) begin
        if (reset || flush) begin
            sb.delete();
        end else begin
            checks++;
            if (out_valid === 2'b01) $display("FAIL out_valid_01 got %b", out_valid);
            else passes++;
            if (!stall) begin
                for (int s = 1; s >= 0; s--) begin
                    if (out_valid[s] === 1'b1) begin
                        ent_t e;
                        checks++;
                        if (sb.size() == 0) begin
                            $display("FAIL sb_underflow slot %0d pc %h required none", s, out_pc[s]);
                        end else begin
                            e = sb.pop_front();
                            deq_total++;
                            if (out_pc[s] !== e.pc || out_instr[s] !== e.instr || out_is_br[s] !== e.br)
                                $display("FAIL sb_slot%0d got pc %h instr %h br %b required pc %h instr %h br %b",
                                         s, out_pc[s], out_instr[s], out_is_br[s], e.pc, e.instr, e.br);
                            else passes++;
                        end
                    end
                end
            end
            if (in_ready === 1'b1) begin
                for (int s = 1; s >= 0; s--) begin
                    if (in_valid[s]) sb.push_back('{pc: in_pc[s], instr: in_instr[s], br: in_is_br[s]});
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [31:0] p1, input logic [31:0] p0,
                         input logic [1:0] br);
        in_valid    = v;
        in_pc[1]    = p1;
        in_pc[0]    = p0;
        in_instr[1] = ~p1;
        in_instr[0] = ~p0;
        in_is_br    = br;
    endtask

    task automatic test_reset;
        reset = 1'b1; flush = 1'b0; stall = 1'b0;
        drive(2'b00, 32'h0, 32'h0, 2'b00);
        tick; tick;
        checks++;
        if (count !== 0) $display("FAIL rst_count got %0d required 0", count); else passes++;
        checks++;
        if (out_valid !== 2'b00) $display("FAIL rst_valid got %b required 00", out_valid); else passes++;
        reset = 1'b0;
        tick;
        checks++;
        if (in_ready !== 1'b1) $display("FAIL rst_ready got %b required 1", in_ready); else passes++;
        checks++;
        if (out_valid !== 2'b00) $display("FAIL post_rst_valid got %b required 00", out_valid); else passes++;
    endtask

    task automatic test_basic_pair;
        drive(2'b11, 32'h100, 32'h104, 2'b00);
        tick;
        drive(2'b00, 32'h0, 32'h0, 2'b00);
        checks++;
        if (out_valid !== 2'b11) $display("FAIL basic_valid got %b required 11", out_valid); else passes++;
        checks++;
        if (out_pc[1] !== 32'h100 || out_pc[0] !== 32'h104)
            $display("FAIL basic_pc got %h/%h required 100/104", out_pc[1], out_pc[0]);
        else passes++;
        tick;
        checks++;
        if (count !== 0 || out_valid !== 2'b00)
            $display("FAIL basic_drain got count %0d valid %b required 0/00", count, out_valid);
        else passes++;
    endtask

    task automatic test_branch_wait;
        drive(2'b10, 32'h200, 32'h0, 2'b10);
        tick;
        drive(2'b10, 32'h204, 32'h0, 2'b00);
        checks++;
        if (out_valid !== 2'b00 || count !== 1)
            $display("FAIL br_wait got valid %b count %0d required 00/1", out_valid, count);
        else passes++;
        tick;
        drive(2'b00, 32'h0, 32'h0, 2'b00);
        checks++;
        if (out_valid !== 2'b11) $display("FAIL br_pair_valid got %b required 11", out_valid); else passes++;
        checks++;
        if (out_pc[1] !== 32'h200 || out_pc[0] !== 32'h204 || out_is_br !== 2'b10)
            $display("FAIL br_pair got %h/%h br %b required 200/204 br 10", out_pc[1], out_pc[0], out_is_br);
        else passes++;
        tick;
        checks++;
        if (count !== 0) $display("FAIL br_drain got %0d required 0", count); else passes++;
    endtask

    task automatic test_held_branch;
        drive(2'b11, 32'h300, 32'h304, 2'b01);
        tick;
        drive(2'b10, 32'h308, 32'h0, 2'b00);
        checks++;
        if (out_valid !== 2'b10 || out_pc[1] !== 32'h300)
            $display("FAIL hold_first got valid %b pc %h required 10/300", out_valid, out_pc[1]);
        else passes++;
        tick;
        drive(2'b00, 32'h0, 32'h0, 2'b00);
        checks++;
        if (out_valid !== 2'b11 || out_pc[1] !== 32'h304 || out_pc[0] !== 32'h308)
            $display("FAIL hold_pair got valid %b pc %h/%h required 11/304/308",
                     out_valid, out_pc[1], out_pc[0]);
        else passes++;
        tick;
        checks++;
        if (count !== 0) $display("FAIL hold_drain got %0d required 0", count); else passes++;
    endtask

    task automatic test_fill_and_drain;
        logic [31:0] pc = 32'h1000;
        int exp;
        stall = 1'b1;
        for (int k = 0; k < 7; k++) begin
            drive(2'b11, pc, pc + 32'd4, 2'b00);
            pc += 32'd8;
            tick;
            checks++;
            if (count !== 2 * (k + 1) || in_ready !== 1'b1)
                $display("FAIL fill_count got %0d ready %b required %0d/1", count, in_ready, 2 * (k + 1));
            else passes++;
        end
        drive(2'b10, pc, 32'h0, 2'b00);
        tick;
        checks++;
        if (count !== 15 || in_ready !== 1'b0)
            $display("FAIL fill_15 got %0d ready %b required 15/0", count, in_ready);
        else passes++;
        drive(2'b11, 32'hBAD0, 32'hBAD4, 2'b00);
        tick;
        checks++;
        if (count !== 15) $display("FAIL fill_reject got %0d required 15", count); else passes++;
        drive(2'b00, 32'h0, 32'h0, 2'b00);
        stall = 1'b0;
        exp = 15;
        while (exp > 0) begin
            exp = (exp >= 2) ? exp - 2 : exp - 1;
            tick;
            checks++;
            if (count !== exp || in_ready !== (exp <= 14))
                $display("FAIL drain_count got %0d ready %b required %0d/%0d", count, in_ready, exp, exp <= 14);
            else passes++;
        end
    endtask

    task automatic test_flush;
        stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive(2'b11, 32'h3000 + 32'(8 * k), 32'h3004 + 32'(8 * k), 2'b00);
            tick;
        end
        checks++;
        if (count !== 10) $display("FAIL flush_fill got %0d required 10", count); else passes++;
        drive(2'b11, 32'hDEAD0000, 32'hDEAD0004, 2'b00);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        drive(2'b00, 32'h0, 32'h0, 2'b00);
        checks++;
        if (count !== 0 || out_valid !== 2'b00 || in_ready !== 1'b1)
            $display("FAIL flush_state got count %0d valid %b ready %b required 0/00/1", count, out_valid, in_ready);
        else passes++;
        stall = 1'b0;
        tick;
        checks++;
        if (out_valid !== 2'b00 || count !== 0)
            $display("FAIL flush_ghost got valid %b count %0d required 00/0", out_valid, count);
        else passes++;
        drive(2'b11, 32'h3100, 32'h3104, 2'b00);
        tick;
        drive(2'b00, 32'h0, 32'h0, 2'b00);
        checks++;
        if (out_valid !== 2'b11 || out_pc[1] !== 32'h3100 || out_pc[0] !== 32'h3104)
            $display("FAIL flush_resume got valid %b pc %h/%h required 11/3100/3104",
                     out_valid, out_pc[1], out_pc[0]);
        else passes++;
        tick;
    endtask

    task automatic test_random_stream;
        int i = 0;
        int cyc = 0;
        int d0 = deq_total;
        logic acc;
        while (i < 40 && cyc < 1000) begin
            drive(2'b11, 32'h4000 + 32'(8 * i), 32'h4004 + 32'(8 * i), 2'b00);
            stall = 1'($urandom_range(0, 1));
            acc = in_ready;
            tick;
            cyc++;
            if (acc) i++;
        end
        checks++;
        if (i != 40) $display("FAIL rand_enq_timeout got %0d pairs required 40", i); else passes++;
        drive(2'b00, 32'h0, 32'h0, 2'b00);
        stall = 1'b0;
        cyc = 0;
        while (count !== 0 && cyc < 100) begin
            tick;
            cyc++;
        end
        tick;
        checks++;
        if (count !== 0) $display("FAIL rand_drain got %0d required 0", count); else passes++;
        checks++;
        if (deq_total - d0 != 80 || sb.size() != 0)
            $display("FAIL rand_total got %0d left %0d required 80/0", deq_total - d0, sb.size());
        else passes++;
    endtask

    initial begin
        test_reset();
        test_basic_pair();
        test_branch_wait();
        test_held_branch();
        test_fill_and_drain();
        test_flush();
        test_random_stream();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/inst_buffer.md
Name: inst_buffer

Overview:
- Two-wide circular FIFO between the fetch stage and decode; it is the producer end of the dual-slot instruction stream that decode forwards into the issue queue.
- Accepts up to two fetched instructions per cycle and presents up to two, in program order, to decode.
- Honours the issue-side backpressure (overflow/stall) and keeps a branch/jump and its delay slot in the same presented pair.
- Slot index [1] is always the older instruction, matching the dual-issue convention downstream.

Parameters:
- DEPTH, 16, number of entries; power of two, at least 4.
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk, input, 1, clock.
- reset, input, 1, synchronous, active-high.
- in_valid[1:0], input, 2, fetched slot valid; [1] is older. Only the patterns 00, 10, 11 and 01 may occur; 01 enqueues slot 0 alone.
- in_pc[1:0], input, 2x32, slot PCs.
- in_instr[1:0], input, 2x32, raw instructions.
- in_is_br[1:0], input, 2, predecoded branch/jump flag.
- in_ready, output, 1, fetch may enqueue this cycle.
- flush, input, 1, discard all entries (redirect or exception).
- stall, input, 1, decode/issue cannot accept; driven by issue overflow OR stallI_de.
- out_valid[1:0], output, 2, presented slot valid; [1] is older; 01 is never driven.
- out_pc[1:0], output, 2x32, presented PCs.
- out_instr[1:0], output, 2x32, presented instructions.
- out_is_br[1:0], output, 2, presented branch flags.
- count, output, PTR_W+1, current occupancy (debug/perf).

Behaviour:
- State: head, tail (PTR_W bits each, wrap modulo DEPTH) and count (0..DEPTH). Storage is registered; outputs are combinational from head/head+1 and count. No fetch-to-decode bypass, so enqueue-to-presentation latency is 1 cycle.
- Reset (sync): head = tail = count = 0; out_valid = 00; in_ready = 1 in the cycle after reset. Storage contents are don't-care.
- in_ready = (DEPTH - count >= 2). It is computed from the current count only; a same-cycle dequeue does not raise it.
- Enqueue: when in_ready and not flush.
  - Each valid slot is written in order, [1] then [0], at tail, tail+1.
  - nenq = popcount(in_valid). tail advances by nenq.
  - in_valid presented while in_ready = 0 is dropped. Fetch is required to hold the data.
- Presentation (candidate A = head, B = head+1):
  - count = 0: out_valid = 00.
  - A is a branch and count = 1: out_valid = 00 (wait for the delay slot).
  - A is a branch and count >= 2: out_valid = 11 (branch and slot paired).
  - A is not a branch, count >= 2 and B is a branch: out_valid = 10 (B is held so it can pair with its slot next cycle).
  - A is not a branch and count = 1: out_valid = 10.
  - Otherwise with count >= 2: out_valid = 11.
- Dequeue: when not stall and not flush, ndeq = popcount(out_valid) and head advances by ndeq.
- Simultaneous enqueue and dequeue: count_next = count + nenq - ndeq. count never exceeds DEPTH and never goes negative (assertions).
- Wrap-around: the pointers wrap naturally. Pairs straddling index DEPTH-1 -> 0 are handled identically to any other pair.
- flush has priority over enqueue, dequeue and stall: head = tail = count = 0 next cycle. Same-cycle fetch data is discarded. out_valid = 00 the cycle after.
- Reset mid-operation behaves as flush; the pointers also return to 0.
- stall = 1: outputs remain combinationally valid and stable (nothing dequeued). Enqueue continues while in_ready.

Test Plan:
- Reset, then enqueue {pc 0x100 (older), 0x104}, stall = 0 -> the next cycle shows out_valid = 11, out_pc = {0x100, 0x104}; the cycle after shows count = 0, out_valid = 00.
- Enqueue only in_valid = 10, branch at pc 0x200 (in_is_br[1] = 1) -> out_valid = 00. The next cycle enqueue 10 with 0x204 -> out_valid = 11 with {0x200, 0x204}.
- Enqueue {0x300 non-branch, 0x304 branch}, then 0x308 -> first out_valid = 10 (0x300), then out_valid = 11 (0x304, 0x308).
- Hold stall = 1 while enqueuing pairs -> count climbs 2, 4, ... to 14 and in_ready drops at count = 15 or 16. An enqueue attempt at count = 15 is rejected and count stays at 15. Release stall -> drains two per cycle and in_ready reasserts at count <= 14.
- Fill to count = 10, assert flush together with in_valid = 11 -> the next cycle has count = 0 and out_valid = 00; the flushed-cycle fetch pair is never presented.
- Run 40 sequential pairs with random stall -> out_pc is strictly increasing by 4 across the wrap at index 15 -> 0, with no loss or duplication (scoreboard).
